// File: rtl/alu_seq_if.sv
// rtl/alu_seq_if.sv - operand/opcode request and result/flag response bundle for alu_seq
`ifndef ALU_SEQ_DEFS
`define ALU_SEQ_DEFS
`define WORD   8
`define OP_SUM 3'd0
`define OP_SUB 3'd1
`define OP_AND 3'd2
`define OP_XOR 3'd3
`define OP_OR  3'd4
`define OP_SHL 3'd5
`define OP_SHR 3'd6
`define OP_MUL 3'd7
`endif

interface alu_seq_if #(parameter int WIDTH = `WORD);
    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic [2:0]       i_opcode;
    logic             o_valid;
    logic             i_ready;
    logic [WIDTH-1:0] o_result;
    logic [WIDTH-1:0] o_result_hi;
    logic             o_zero;
    logic             o_cf;
    logic             o_of;

    modport slave (
        input  i_valid, i_a, i_b, i_opcode, i_ready,
        output o_ready, o_valid, o_result, o_result_hi, o_zero, o_cf, o_of
    );

    modport master (
        output i_valid, i_a, i_b, i_opcode, i_ready,
        input  o_ready, o_valid, o_result, o_result_hi, o_zero, o_cf, o_of
    );
endinterface

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked registered ALU; ALU_SEQ_MUL_EN adds a multi-cycle shift-add multiplier
`ifndef ALU_SEQ_DEFS
`define ALU_SEQ_DEFS
`define WORD   8
`define OP_SUM 3'd0
`define OP_SUB 3'd1
`define OP_AND 3'd2
`define OP_XOR 3'd3
`define OP_OR  3'd4
`define OP_SHL 3'd5
`define OP_SHR 3'd6
`define OP_MUL 3'd7
`endif

module alu_seq #(
    parameter int WIDTH = `WORD
) (
    input logic   i_clk,
    input logic   i_rst_n,
    alu_seq_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);
    localparam int MSB = WIDTH - 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DONE = 2'd1
`ifdef ALU_SEQ_MUL_EN
        , S_EXEC = 2'd2
`endif
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] r_result_hi;
    logic             r_zero;
    logic             r_cf;
    logic             r_of;

    logic             w_ready;
    logic             w_load;
    logic [WIDTH-1:0] w_res;
    logic             w_cf;
    logic             w_of;
    logic [SHW-1:0]   w_n;
    logic [WIDTH:0]   w_add;
    logic [WIDTH:0]   w_sub;
    logic [WIDTH:0]   w_shl;
    logic [WIDTH:0]   w_shr;

    // Extra guard bit on each shift catches the last bit shifted out; it is 0 when n == 0.
    assign w_n   = bus.i_b[SHW-1:0];
    assign w_add = {1'b0, bus.i_a} + {1'b0, bus.i_b};
    assign w_sub = {1'b0, bus.i_a} - {1'b0, bus.i_b};
    assign w_shl = {1'b0, bus.i_a} << w_n;
    assign w_shr = {bus.i_a, 1'b0} >> w_n;

    always_comb begin
        w_res = '0;
        w_cf  = 1'b0;
        w_of  = 1'b0;
        case (bus.i_opcode)
            `OP_SUM: begin
                w_res = w_add[WIDTH-1:0];
                w_cf  = w_add[WIDTH];
                w_of  = (bus.i_a[MSB] == bus.i_b[MSB]) & (w_add[MSB] != bus.i_a[MSB]);
            end
            `OP_SUB: begin
                w_res = w_sub[WIDTH-1:0];
                w_cf  = w_sub[WIDTH];
                w_of  = (bus.i_a[MSB] != bus.i_b[MSB]) & (w_sub[MSB] != bus.i_a[MSB]);
            end
            `OP_AND: w_res = bus.i_a & bus.i_b;
            `OP_XOR: w_res = bus.i_a ^ bus.i_b;
            `OP_OR:  w_res = bus.i_a | bus.i_b;
            `OP_SHL: begin
                w_res = w_shl[WIDTH-1:0];
                w_cf  = w_shl[WIDTH];
            end
            `OP_SHR: begin
                w_res = w_shr[WIDTH:1];
                w_cf  = w_shr[0];
            end
            default: ;
        endcase
    end

`ifdef ALU_SEQ_MUL_EN
    localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

    logic [SHW-1:0]     r_cnt;
    logic [WIDTH-1:0]   r_mcand;
    logic [2*WIDTH-1:0] r_prod;
    logic               w_is_mul;
    logic               w_start;
    logic               w_mul_done;
    logic [WIDTH:0]     w_step;
    logic [2*WIDTH-1:0] w_prod_next;

    // Right-shifting product register: multiplier starts in the low half and drains out bit by bit.
    assign w_is_mul    = (bus.i_opcode == `OP_MUL);
    assign w_step      = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_mcand} : '0);
    assign w_prod_next = {w_step, r_prod[WIDTH-1:1]};
`endif

    always_comb begin
        w_state_next = r_state;
        w_ready      = 1'b0;
        w_load       = 1'b0;
`ifdef ALU_SEQ_MUL_EN
        w_start      = 1'b0;
        w_mul_done   = 1'b0;
`endif
        case (r_state)
            S_IDLE: w_ready = 1'b1;
            S_DONE: begin
                w_ready = bus.i_ready;
                if (bus.i_ready)
                    w_state_next = S_IDLE;
            end
`ifdef ALU_SEQ_MUL_EN
            S_EXEC: begin
                if (r_cnt == CNT_LAST) begin
                    w_mul_done   = 1'b1;
                    w_state_next = S_DONE;
                end
            end
`endif
            default: w_state_next = S_IDLE;
        endcase
        if (w_ready && bus.i_valid) begin
`ifdef ALU_SEQ_MUL_EN
            if (w_is_mul) begin
                w_start      = 1'b1;
                w_state_next = S_EXEC;
            end else begin
                w_load       = 1'b1;
                w_state_next = S_DONE;
            end
`else
            w_load       = 1'b1;
            w_state_next = S_DONE;
`endif
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_state_next;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_result    <= '0;
            r_result_hi <= '0;
            r_zero      <= 1'b0;
            r_cf        <= 1'b0;
            r_of        <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            r_cnt       <= '0;
            r_mcand     <= '0;
            r_prod      <= '0;
`endif
        end else begin
            if (w_load) begin
                r_result    <= w_res;
                r_result_hi <= '0;
                r_zero      <= (w_res == '0);
                r_cf        <= w_cf;
                r_of        <= w_of;
            end
`ifdef ALU_SEQ_MUL_EN
            if (w_start) begin
                r_cnt   <= '0;
                r_mcand <= bus.i_a;
                r_prod  <= {{WIDTH{1'b0}}, bus.i_b};
            end else if (r_state == S_EXEC) begin
                r_cnt  <= r_cnt + 1'b1;
                r_prod <= w_prod_next;
            end
            if (w_mul_done) begin
                r_result    <= w_prod_next[WIDTH-1:0];
                r_result_hi <= w_prod_next[2*WIDTH-1:WIDTH];
                r_zero      <= (w_prod_next[WIDTH-1:0] == '0);
                r_cf        <= (w_prod_next[2*WIDTH-1:WIDTH] != '0);
                r_of        <= 1'b0;
            end
`endif
        end
    end

    assign bus.o_ready     = w_ready;
    assign bus.o_valid     = (r_state == S_DONE);
    assign bus.o_result    = r_result;
    assign bus.o_result_hi = r_result_hi;
    assign bus.o_zero      = r_zero;
    assign bus.o_cf        = r_cf;
    assign bus.o_of        = r_of;
endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - table-driven bench for alu_seq at WIDTH 8 and 16
`ifndef ALU_SEQ_DEFS
`define ALU_SEQ_DEFS
`define WORD   8
`define OP_SUM 3'd0
`define OP_SUB 3'd1
`define OP_AND 3'd2
`define OP_XOR 3'd3
`define OP_OR  3'd4
`define OP_SHL 3'd5
`define OP_SHR 3'd6
`define OP_MUL 3'd7
`endif

module tb_alu_seq;
`ifdef ALU_SEQ_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    typedef struct {
        bit          w16;
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic [15:0] hi;
        logic        zero;
        logic        cf;
        logic        of;
        int          lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_seq_if #(.WIDTH(8))  bus8 ();
    alu_seq_if #(.WIDTH(16)) bus16 ();

    alu_seq #(.WIDTH(8))  u_alu8  (.i_clk(clk), .i_rst_n(rst_n), .bus(bus8));
    alu_seq #(.WIDTH(16)) u_alu16 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus16));

    int n_vec = 0;
    int n_miss = 0;
    vec_t vecs[$];

    function automatic vec_t mk(bit w16, logic [2:0] op, logic [15:0] a, logic [15:0] b,
                                logic [15:0] res, logic [15:0] hi, logic zero, logic cf,
                                logic of, int lat);
        vec_t v;
        v.w16 = w16; v.op = op; v.a = a; v.b = b; v.res = res; v.hi = hi;
        v.zero = zero; v.cf = cf; v.of = of; v.lat = lat;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic sample(input bit w16, output logic [15:0] res, output logic [15:0] hi,
                          output logic zero, output logic cf, output logic of,
                          output logic vld, output logic rdy);
        if (w16) begin
            res = bus16.o_result; hi = bus16.o_result_hi; zero = bus16.o_zero;
            cf = bus16.o_cf; of = bus16.o_of; vld = bus16.o_valid; rdy = bus16.o_ready;
        end else begin
            res = {8'h00, bus8.o_result}; hi = {8'h00, bus8.o_result_hi}; zero = bus8.o_zero;
            cf = bus8.o_cf; of = bus8.o_of; vld = bus8.o_valid; rdy = bus8.o_ready;
        end
    endtask

    task automatic check_cleared(input string tag);
        logic [15:0] res, hi;
        logic zero, cf, of, vld, rdy;
        sample(1'b0, res, hi, zero, cf, of, vld, rdy);
        check({tag, ".valid"}, 32'(vld), 32'd0);
        check({tag, ".ready"}, 32'(rdy), 32'd1);
        check({tag, ".result"}, 32'(res), 32'd0);
        check({tag, ".result_hi"}, 32'(hi), 32'd0);
        check({tag, ".zero"}, 32'(zero), 32'd0);
        check({tag, ".cf"}, 32'(cf), 32'd0);
        check({tag, ".of"}, 32'(of), 32'd0);
    endtask

    // Drives one op, then scrambles the operands to prove they were captured on the accept edge.
    task automatic run_op(input bit w16, input logic [2:0] op, input logic [15:0] a,
                          input logic [15:0] b, output int lat, output int busy);
        logic [15:0] res, hi;
        logic zero, cf, of, vld, rdy;
        if (w16) begin
            bus16.i_opcode = op; bus16.i_a = a; bus16.i_b = b; bus16.i_valid = 1'b1;
        end else begin
            bus8.i_opcode = op; bus8.i_a = a[7:0]; bus8.i_b = b[7:0]; bus8.i_valid = 1'b1;
        end
        @(posedge clk);
        #1;
        bus8.i_valid = 1'b0;
        bus16.i_valid = 1'b0;
        bus8.i_a = 8'($urandom); bus8.i_b = 8'($urandom); bus8.i_opcode = 3'($urandom);
        bus16.i_a = 16'($urandom); bus16.i_b = 16'($urandom); bus16.i_opcode = 3'($urandom);
        lat = 1;
        busy = 0;
        sample(w16, res, hi, zero, cf, of, vld, rdy);
        while (!vld && lat < 60) begin
            if (!rdy) busy++;
            @(posedge clk);
            #1;
            lat++;
            sample(w16, res, hi, zero, cf, of, vld, rdy);
        end
    endtask

    task automatic ack();
        bus8.i_ready = 1'b1;
        bus16.i_ready = 1'b1;
        @(posedge clk);
        #1;
        bus8.i_ready = 1'b0;
        bus16.i_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, busy;
        logic [15:0] res, hi;
        logic zero, cf, of, vld, rdy;

        bus8.i_valid = 1'b0;  bus8.i_ready = 1'b0;  bus8.i_a = '0;  bus8.i_b = '0;  bus8.i_opcode = '0;
        bus16.i_valid = 1'b0; bus16.i_ready = 1'b0; bus16.i_a = '0; bus16.i_b = '0; bus16.i_opcode = '0;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_cleared("reset");
        rst_n = 1'b1;

        vecs.push_back(mk(0, `OP_SUM, 16'h00FF, 16'h0001, 16'h0000, 16'h0, 1, 1, 0, 1));
        vecs.push_back(mk(0, `OP_SUB, 16'h0080, 16'h0001, 16'h007F, 16'h0, 0, 0, 1, 1));
        vecs.push_back(mk(0, `OP_SUB, 16'h0003, 16'h0005, 16'h00FE, 16'h0, 0, 1, 0, 1));
        vecs.push_back(mk(0, `OP_SUM, 16'h007F, 16'h0001, 16'h0080, 16'h0, 0, 0, 1, 1));
        vecs.push_back(mk(0, `OP_AND, 16'h00F0, 16'h003C, 16'h0030, 16'h0, 0, 0, 0, 1));
        vecs.push_back(mk(0, `OP_XOR, 16'h00F0, 16'h003C, 16'h00CC, 16'h0, 0, 0, 0, 1));
        vecs.push_back(mk(0, `OP_OR,  16'h00F0, 16'h003C, 16'h00FC, 16'h0, 0, 0, 0, 1));
        vecs.push_back(mk(0, `OP_OR,  16'h0000, 16'h0000, 16'h0000, 16'h0, 1, 0, 0, 1));
        vecs.push_back(mk(0, `OP_SHL, 16'h0003, 16'h0007, 16'h0080, 16'h0, 0, 1, 0, 1));
        vecs.push_back(mk(0, `OP_SHR, 16'h0081, 16'h0009, 16'h0040, 16'h0, 0, 1, 0, 1));
        vecs.push_back(mk(0, `OP_SHR, 16'h0081, 16'h0007, 16'h0001, 16'h0, 0, 0, 0, 1));
        vecs.push_back(mk(0, `OP_SHL, 16'h0080, 16'h0000, 16'h0080, 16'h0, 0, 0, 0, 1));
        vecs.push_back(mk(1, `OP_SHL, 16'h8001, 16'h0001, 16'h0002, 16'h0, 0, 1, 0, 1));
        vecs.push_back(mk(1, `OP_SHR, 16'h8001, 16'h0010, 16'h8001, 16'h0, 0, 0, 0, 1));
        vecs.push_back(mk(1, `OP_SUM, 16'hFFFF, 16'h0001, 16'h0000, 16'h0, 1, 1, 0, 1));
        vecs.push_back(mk(1, `OP_SUB, 16'h0000, 16'h0001, 16'hFFFF, 16'h0, 0, 1, 0, 1));
        vecs.push_back(mk(1, `OP_SUB, 16'h8000, 16'h0001, 16'h7FFF, 16'h0, 0, 0, 1, 1));
        if (MUL_EN) begin
            vecs.push_back(mk(0, `OP_MUL, 16'h00FF, 16'h00FF, 16'h0001, 16'h00FE, 0, 1, 0, 9));
            vecs.push_back(mk(0, `OP_MUL, 16'h000F, 16'h0010, 16'h00F0, 16'h0000, 0, 0, 0, 9));
            vecs.push_back(mk(0, `OP_MUL, 16'h0000, 16'h0005, 16'h0000, 16'h0000, 1, 0, 0, 9));
            vecs.push_back(mk(1, `OP_MUL, 16'h1234, 16'h0100, 16'h3400, 16'h0012, 0, 1, 0, 17));
        end else begin
            vecs.push_back(mk(0, `OP_MUL, 16'h00FF, 16'h00FF, 16'h0000, 16'h0000, 1, 0, 0, 1));
            vecs.push_back(mk(1, `OP_MUL, 16'h1234, 16'h0100, 16'h0000, 16'h0000, 1, 0, 0, 1));
        end

        foreach (vecs[i]) begin
            sample(vecs[i].w16, res, hi, zero, cf, of, vld, rdy);
            check($sformatf("v%0d.ready_before", i), 32'(rdy), 32'd1);
            run_op(vecs[i].w16, vecs[i].op, vecs[i].a, vecs[i].b, lat, busy);
            sample(vecs[i].w16, res, hi, zero, cf, of, vld, rdy);
            check($sformatf("v%0d.latency", i), 32'(lat), 32'(vecs[i].lat));
            check($sformatf("v%0d.busy_cycles", i), 32'(busy), 32'(vecs[i].lat - 1));
            check($sformatf("v%0d.result", i), 32'(res), 32'(vecs[i].res));
            check($sformatf("v%0d.result_hi", i), 32'(hi), 32'(vecs[i].hi));
            check($sformatf("v%0d.zero", i), 32'(zero), 32'(vecs[i].zero));
            check($sformatf("v%0d.cf", i), 32'(cf), 32'(vecs[i].cf));
            check($sformatf("v%0d.of", i), 32'(of), 32'(vecs[i].of));
            ack();
            sample(vecs[i].w16, res, hi, zero, cf, of, vld, rdy);
            check($sformatf("v%0d.valid_after_ack", i), 32'(vld), 32'd0);
        end

        // Backpressure: result must hold for 5 stalled cycles, then a back-to-back AND is taken.
        run_op(1'b0, `OP_SUM, 16'h0012, 16'h0034, lat, busy);
        check("bp.latency", 32'(lat), 32'd1);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            sample(1'b0, res, hi, zero, cf, of, vld, rdy);
            check($sformatf("bp%0d.valid", k), 32'(vld), 32'd1);
            check($sformatf("bp%0d.result", k), 32'(res), 32'h46);
            check($sformatf("bp%0d.ready", k), 32'(rdy), 32'd0);
        end
        bus8.i_opcode = `OP_AND; bus8.i_a = 8'hF0; bus8.i_b = 8'h3C;
        bus8.i_valid = 1'b1;
        bus8.i_ready = 1'b1;
        #1;
        check("b2b.ready_comb", 32'(bus8.o_ready), 32'd1);
        @(posedge clk);
        #1;
        bus8.i_valid = 1'b0;
        bus8.i_ready = 1'b0;
        sample(1'b0, res, hi, zero, cf, of, vld, rdy);
        check("b2b.valid", 32'(vld), 32'd1);
        check("b2b.result", 32'(res), 32'h30);
        check("b2b.cf", 32'(cf), 32'd0);
        ack();

        // Reset asserted three cycles into a multiply must abort it with everything cleared.
        bus8.i_opcode = `OP_MUL; bus8.i_a = 8'hFF; bus8.i_b = 8'hFF;
        bus8.i_valid = 1'b1;
        @(posedge clk);
        #1;
        bus8.i_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_cleared("midrst");
        @(posedge clk);
        #1;
        check("midrst.still_idle", 32'(bus8.o_valid), 32'd0);
        run_op(1'b0, `OP_SUM, 16'h0002, 16'h0003, lat, busy);
        sample(1'b0, res, hi, zero, cf, of, vld, rdy);
        check("postrst.latency", 32'(lat), 32'd1);
        check("postrst.result", 32'(res), 32'd5);
        check("postrst.zero", 32'(zero), 32'd0);
        ack();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Handshaked, parametrised successor to the 8-bit combinational ALU.
- Operand width is set by WIDTH.
- Results and flags are registered.
- Adds OR, shift-left and shift-right, plus an optional multi-cycle shift-add multiplier.
- Sits between the operand-fetch stage and the register write-back stage.
- Uses valid/ready on both the input and the output side.

Parameters:
WIDTH, `WORD, operand/result width; must be >= 2. Carry is taken from bit WIDTH, never a hard-coded index.
SHW, $clog2(WIDTH), localparam, width of the shift-amount field taken from i_b[SHW-1:0].

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  synchronous active-low reset
i_valid  in  1  operands and opcode valid
o_ready  out  1  block can accept an operation this cycle
i_a  in  WIDTH  operand A
i_b  in  WIDTH  operand B; for shifts, i_b[SHW-1:0] is the shift amount
i_opcode  in  3  `OP_SUM, `OP_SUB, `OP_AND, `OP_XOR, `OP_OR, `OP_SHL, `OP_SHR, `OP_MUL (all from specs.vh)
o_valid  out  1  result and flags valid
i_ready  in  1  downstream accepts the result
o_result  out  WIDTH  result; for MUL, the low half of the product
o_result_hi  out  WIDTH  MUL: high half of the product; 0 for every other op
o_zero  out  1  o_result == 0 (o_result only; o_result_hi is not included)
o_cf  out  1  carry/borrow/shift-out flag
o_of  out  1  signed overflow (SUM/SUB only, else 0)

Behaviour:
- Clock and reset: one clock, i_clk. Reset is synchronous on i_rst_n, active-low.
- Reset state: state=IDLE; o_valid, o_result, o_result_hi, o_zero, o_cf, o_of all 0.
- Reset mid-operation: reset during EXEC aborts the multiply; no result is produced.
- States: IDLE, EXEC, DONE.
- o_ready = (state==IDLE) | (state==DONE & i_ready). This path is combinational from i_ready.
- Accept: i_valid & o_ready. Operands and opcode are captured on that edge; later changes on the inputs are ignored.
- Single-cycle ops (everything except MUL):
  - Result and flags are registered on the accept edge.
  - Next state is DONE, so o_valid rises the cycle after accept (latency 1).
- MUL:
  - The accept edge enters EXEC with counter = 0.
  - One shift-add step per cycle, WIDTH steps in total.
  - On step WIDTH-1, the result is registered and the state goes to DONE.
  - Latency: WIDTH+1 cycles from accept to o_valid.
  - o_ready = 0 throughout EXEC.
- DONE:
  - o_valid = 1; outputs are held stable until i_ready.
  - i_ready=1, i_valid=0: go to IDLE, o_valid=0 next cycle.
  - i_ready=1, i_valid=1: the new op is accepted in the same cycle (back-to-back). A single-cycle op stays in DONE with the new result; MUL goes to EXEC.
- Arithmetic rules:
  - SUM: result = (a+b) mod 2^WIDTH. cf = bit WIDTH of the (WIDTH+1)-bit sum. of = (a[msb]==b[msb]) & (r[msb]!=a[msb]).
  - SUB: result = (a-b) mod 2^WIDTH. cf = borrow (a<b unsigned). of = (a[msb]!=b[msb]) & (r[msb]!=a[msb]).
  - AND, XOR, OR: cf = 0, of = 0.
  - SHL and SHR are logical shifts with zero fill. The shift amount is n = i_b[SHW-1:0]; higher bits of i_b are ignored.
  - SHL/SHR with n>0: cf = last bit shifted out, i.e. a[WIDTH-n] for SHL and a[n-1] for SHR.
  - SHL/SHR with n=0: result = a, cf = 0.
  - MUL is unsigned: {o_result_hi, o_result} = a*b. cf = (o_result_hi != 0). of = 0.
- o_zero is computed from the registered result.
- o_result_hi = 0 for all non-MUL ops.

Optional Feature:
Macro ALU_SEQ_MUL_EN.
- Defined: `OP_MUL behaves as above, and the EXEC state and counter are built.
- Undefined:
  - No EXEC state; the multiplier logic is absent.
  - `OP_MUL is treated as single-cycle: result 0, o_result_hi 0, o_zero 1, o_cf 0, o_of 0.
  - Latency is 1 for every opcode.

Test Plan:
- WIDTH=8, SUM a=0xFF b=0x01 -> o_valid 1 cycle after accept: o_result=0x00, o_zero=1, o_cf=1, o_of=0.
- WIDTH=8, SUB a=0x80 b=0x01 -> o_result=0x7F, o_cf=0, o_of=1. Then SUB a=0x03 b=0x05 -> o_result=0xFE, o_cf=1.
- WIDTH=16, SHL a=0x8001 b=0x0001 -> o_result=0x0002, o_cf=1. Then SHR a=0x8001 b=0x0010 (n=0) -> o_result=0x8001, o_cf=0.
- ALU_SEQ_MUL_EN defined, WIDTH=8, MUL a=0xFF b=0xFF -> o_ready=0 for 8 cycles, then o_valid: o_result=0x01, o_result_hi=0xFE, o_cf=1. The same op with the macro undefined gives o_result=0, o_zero=1, latency 1.
- Backpressure and back-to-back: hold i_ready=0 for 5 cycles after o_valid -> outputs stable and o_ready=0. Then raise i_ready with i_valid=1 (AND 0xF0,0x3C) -> accepted in the same cycle, next o_result=0x30.
- Pull i_rst_n low 3 cycles into a MUL -> next cycle: o_valid=0, o_ready=1, all outputs 0. Then a fresh SUM 2+3 returns 5.
